// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external 16-bit SRAM (used byte-wide) between
// three requesters using a registered sequencer.
//   - video fetch port (reads), fixed highest priority
//   - ioctl loader port (writes)
//   - CPU port (reads and writes)
// The loader and the CPU share the SRAM by a round-robin pointer.
// Every SRAM-side output and every ack comes straight from a flop, so no
// combinational path runs from the requests to the pins.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   vidRq/vidA          video request (level) and byte address
//   vidQ/vidAck         video read data and one-cycle completion pulse
//   ldRq/ldA/ldD        loader request (level), byte address, write data
//   ldAck               loader completion pulse
//   cpuRq/cpuWe/cpuA/cpuD  CPU request, direction (1=write), address, data
//   cpuQ/cpuAck         CPU read data and completion pulse
//   sramA               SRAM word address (byte address >> 1)
//   sramUb/sramLb       active-low byte-lane enables
//   sramOe/sramWe       active-low output/write strobes
//   sramDqO/sramDqOe    write data (byte on both lanes) and drive enable
//   sramDqI             data sampled from the SRAM bus
module sram_arbiter #(
  parameter int AW = 22
) (
  input  logic          clock,
  input  logic          reset,
  // video port
  input  logic          vidRq,
  input  logic [AW-1:0] vidA,
  output logic [7:0]    vidQ,
  output logic          vidAck,
  // loader port
  input  logic          ldRq,
  input  logic [AW-1:0] ldA,
  input  logic [7:0]    ldD,
  output logic          ldAck,
  // CPU port
  input  logic          cpuRq,
  input  logic          cpuWe,
  input  logic [AW-1:0] cpuA,
  input  logic [7:0]    cpuD,
  output logic [7:0]    cpuQ,
  output logic          cpuAck,
  // SRAM side
  output logic [AW-2:0] sramA,
  output logic          sramUb,
  output logic          sramLb,
  output logic          sramOe,
  output logic          sramWe,
  output logic [15:0]   sramDqO,
  output logic          sramDqOe,
  input  logic [15:0]   sramDqI
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_WR0,
    S_WR1,
    S_WR2
  } state_t;

  typedef enum logic [1:0] {
    P_VID,
    P_LD,
    P_CPU
  } port_t;

  // Round-robin pointer: which of loader/CPU wins when both are pending.
  localparam logic RR_LD  = 1'b0;
  localparam logic RR_CPU = 1'b1;

  state_t        state_q, state_d;
  port_t         port_q, port_d;
  logic          rr_q, rr_d;
  logic          hi_q, hi_d;          // latched byte lane (address bit 0)
  logic [AW-2:0] addr_q, addr_d;
  logic          ub_q, ub_d;
  logic          lb_q, lb_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic [15:0]   dqo_q, dqo_d;
  logic          dqoe_q, dqoe_d;
  logic          vidAck_q, vidAck_d;
  logic          ldAck_q, ldAck_d;
  logic          cpuAck_q, cpuAck_d;
  logic [7:0]    vidQ_q, vidQ_d;
  logic [7:0]    cpuQ_q, cpuQ_d;

  // A port whose ack is high this cycle is masked, so a requester that
  // drops its level one cycle late is not served twice.
  logic vid_v, ld_v, cpu_v;
  logic gnt_vid, gnt_ld, gnt_cpu, gnt_any;
  logic [AW-1:0] g_addr;
  logic [7:0]    g_data;
  logic          g_wr;
  logic [7:0]    rd_byte;

  assign vid_v = vidRq & ~vidAck_q;
  assign ld_v  = ldRq  & ~ldAck_q;
  assign cpu_v = cpuRq & ~cpuAck_q;

  // Video wins outright; a lone loader/CPU request wins regardless of rr.
  assign gnt_vid = vid_v;
  assign gnt_ld  = ~vid_v & ld_v & (~cpu_v | (rr_q == RR_LD));
  assign gnt_cpu = ~vid_v & cpu_v & ~gnt_ld;
  assign gnt_any = gnt_vid | gnt_ld | gnt_cpu;

  always_comb begin
    g_addr = vidA;
    g_data = 8'h00;
    g_wr   = 1'b0;
    if (gnt_ld) begin
      g_addr = ldA;
      g_data = ldD;
      g_wr   = 1'b1;
    end else if (gnt_cpu) begin
      g_addr = cpuA;
      g_data = cpuD;
      g_wr   = cpuWe;
    end
  end

  assign rd_byte = hi_q ? sramDqI[15:8] : sramDqI[7:0];

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    rr_d     = rr_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    ub_d     = ub_q;
    lb_d     = lb_q;
    oe_d     = 1'b1;
    we_d     = 1'b1;
    dqo_d    = dqo_q;
    dqoe_d   = dqoe_q;
    vidAck_d = 1'b0;
    ldAck_d  = 1'b0;
    cpuAck_d = 1'b0;
    vidQ_d   = vidQ_q;
    cpuQ_d   = cpuQ_q;

    unique case (state_q)
      S_IDLE: begin
        ub_d   = 1'b1;
        lb_d   = 1'b1;
        dqoe_d = 1'b0;
        if (gnt_any) begin
          if (gnt_vid)      port_d = P_VID;
          else if (gnt_ld)  port_d = P_LD;
          else              port_d = P_CPU;
          // The loader/CPU winner hands priority to the other one.
          if (gnt_ld)  rr_d = RR_CPU;
          if (gnt_cpu) rr_d = RR_LD;
          addr_d = g_addr[AW-1:1];
          hi_d   = g_addr[0];
          ub_d   = ~g_addr[0];
          lb_d   = g_addr[0];
          if (g_wr) begin
            dqo_d   = {g_data, g_data};
            dqoe_d  = 1'b1;
            state_d = S_WR0;
          end else begin
            oe_d    = 1'b0;
            state_d = S_RD0;
          end
        end
      end
      S_RD0: begin
        oe_d    = 1'b0;
        state_d = S_RD1;
      end
      S_RD1: begin
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        state_d = S_IDLE;
        if (port_q == P_VID) begin
          vidQ_d   = rd_byte;
          vidAck_d = 1'b1;
        end else begin
          cpuQ_d   = rd_byte;
          cpuAck_d = 1'b1;
        end
      end
      S_WR0: begin
        // Data has had a full cycle on the bus before the write strobe falls.
        we_d    = 1'b0;
        state_d = S_WR1;
      end
      S_WR1: begin
        // Strobe rises while address and data are still held (WR2).
        state_d = S_WR2;
      end
      S_WR2: begin
        dqoe_d  = 1'b0;
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        state_d = S_IDLE;
        if (port_q == P_LD) ldAck_d  = 1'b1;
        else                cpuAck_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      port_q   <= P_VID;
      rr_q     <= RR_LD;
      hi_q     <= 1'b0;
      addr_q   <= '0;
      ub_q     <= 1'b1;
      lb_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      dqo_q    <= 16'h0000;
      dqoe_q   <= 1'b0;
      vidAck_q <= 1'b0;
      ldAck_q  <= 1'b0;
      cpuAck_q <= 1'b0;
      vidQ_q   <= 8'h00;
      cpuQ_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      rr_q     <= rr_d;
      hi_q     <= hi_d;
      addr_q   <= addr_d;
      ub_q     <= ub_d;
      lb_q     <= lb_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      dqo_q    <= dqo_d;
      dqoe_q   <= dqoe_d;
      vidAck_q <= vidAck_d;
      ldAck_q  <= ldAck_d;
      cpuAck_q <= cpuAck_d;
      vidQ_q   <= vidQ_d;
      cpuQ_q   <= cpuQ_d;
    end
  end

  assign sramA    = addr_q;
  assign sramUb   = ub_q;
  assign sramLb   = lb_q;
  assign sramOe   = oe_q;
  assign sramWe   = we_q;
  assign sramDqO  = dqo_q;
  assign sramDqOe = dqoe_q;
  assign vidAck   = vidAck_q;
  assign ldAck    = ldAck_q;
  assign cpuAck   = cpuAck_q;
  assign vidQ     = vidQ_q;
  assign cpuQ     = cpuQ_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter. Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge.
module tb_sram_arbiter;
  localparam int AW = 22;

  logic          clock = 1'b0;
  logic          reset;
  logic          vidRq, ldRq, cpuRq, cpuWe;
  logic [AW-1:0] vidA, ldA, cpuA;
  logic [7:0]    ldD, cpuD;
  logic [7:0]    vidQ, cpuQ;
  logic          vidAck, ldAck, cpuAck;
  logic [AW-2:0] sramA;
  logic          sramUb, sramLb, sramOe, sramWe, sramDqOe;
  logic [15:0]   sramDqO, sramDqI;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  sram_arbiter #(.AW(AW)) dut (
    .clock(clock), .reset(reset),
    .vidRq(vidRq), .vidA(vidA), .vidQ(vidQ), .vidAck(vidAck),
    .ldRq(ldRq), .ldA(ldA), .ldD(ldD), .ldAck(ldAck),
    .cpuRq(cpuRq), .cpuWe(cpuWe), .cpuA(cpuA), .cpuD(cpuD),
    .cpuQ(cpuQ), .cpuAck(cpuAck),
    .sramA(sramA), .sramUb(sramUb), .sramLb(sramLb),
    .sramOe(sramOe), .sramWe(sramWe),
    .sramDqO(sramDqO), .sramDqOe(sramDqOe), .sramDqI(sramDqI)
  );

  // Advance to the next falling edge and check the bus invariants there.
  task automatic tick();
    @(negedge clock);
    nvec++;
    if (sramOe === 1'b0 && sramWe === 1'b0) begin
      nerr++;
      $display("FAIL strobe_overlap oe=%b we=%b expected never both 0", sramOe, sramWe);
    end
    nvec++;
    if (sramDqOe === 1'b1 && (sramOe !== 1'b1 || (sramUb !== 1'b0 && sramLb !== 1'b0))) begin
      nerr++;
      $display("FAIL dqoe_outside_write dqoe=%b oe=%b ub=%b lb=%b", sramDqOe, sramOe, sramUb, sramLb);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    nvec++;
    if ({sramOe, sramWe, sramUb, sramLb, sramDqOe} !== 5'b11110) begin
      nerr++;
      $display("FAIL reset_strobes got oe,we,ub,lb,dqoe=%b expected 11110",
               {sramOe, sramWe, sramUb, sramLb, sramDqOe});
    end
    nvec++;
    if (sramA !== '0 || sramDqO !== 16'h0000) begin
      nerr++;
      $display("FAIL reset_bus got A=%h DqO=%h expected 0/0", sramA, sramDqO);
    end
    nvec++;
    if ({vidAck, ldAck, cpuAck} !== 3'b000 || vidQ !== 8'h00 || cpuQ !== 8'h00) begin
      nerr++;
      $display("FAIL reset_port got acks=%b vidQ=%h cpuQ=%h expected 000/00/00",
               {vidAck, ldAck, cpuAck}, vidQ, cpuQ);
    end
    reset = 1'b0;
    tick();
    nvec++;
    if (sramOe !== 1'b1 || {vidAck, ldAck, cpuAck} !== 3'b000) begin
      nerr++;
      $display("FAIL idle_after_reset got oe=%b acks=%b expected 1/000", sramOe, {vidAck, ldAck, cpuAck});
    end
  endtask

  task automatic test_vid_read();
    sramDqI = 16'hA55A;
    vidA    = 22'h000003;
    vidRq   = 1'b1;
    tick();
    nvec++;
    if (sramA !== 21'h000001 || sramUb !== 1'b0 || sramLb !== 1'b1 || sramOe !== 1'b0 || vidAck !== 1'b0) begin
      nerr++;
      $display("FAIL vid_rd0 got A=%h ub=%b lb=%b oe=%b ack=%b expected 000001/0/1/0/0",
               sramA, sramUb, sramLb, sramOe, vidAck);
    end
    tick();
    nvec++;
    if (sramOe !== 1'b0 || vidAck !== 1'b0) begin
      nerr++;
      $display("FAIL vid_rd1 got oe=%b ack=%b expected 0/0", sramOe, vidAck);
    end
    tick();
    nvec++;
    if (vidAck !== 1'b1 || vidQ !== 8'hA5 || sramOe !== 1'b1 || sramUb !== 1'b1) begin
      nerr++;
      $display("FAIL vid_ack got ack=%b Q=%h oe=%b ub=%b expected 1/a5/1/1", vidAck, vidQ, sramOe, sramUb);
    end
    vidRq = 1'b0;
    tick();
    nvec++;
    if (vidAck !== 1'b0 || sramOe !== 1'b1 || vidQ !== 8'hA5) begin
      nerr++;
      $display("FAIL vid_after got ack=%b oe=%b Q=%h expected 0/1/a5", vidAck, sramOe, vidQ);
    end
  endtask

  // Request held through the ack: the ack cycle is masked, so the second
  // grant comes one edge later and the acks land 4 apart (3 and 7).
  task automatic test_mask();
    vidA  = 22'h000003;
    vidRq = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      nvec++;
      if (vidAck !== (k == 3 || k == 7)) begin
        nerr++;
        $display("FAIL mask_ack k=%0d got %b expected %b", k, vidAck, (k == 3 || k == 7));
      end
      if (k == 7) vidRq = 1'b0;
    end
  endtask

  // Loader write and CPU read held together: ld, cpu, ld, cpu.
  task automatic test_rr();
    ldA = 22'h000020; ldD = 8'h11; ldRq = 1'b1;
    cpuA = 22'h000040; cpuWe = 1'b0; cpuRq = 1'b1;
    sramDqI = 16'hA55A;
    for (int k = 1; k <= 17; k++) begin
      tick();
      nvec++;
      if (ldAck !== (k == 4 || k == 11) || cpuAck !== (k == 7 || k == 14)) begin
        nerr++;
        $display("FAIL rr_order k=%0d got ld=%b cpu=%b expected ld=%b cpu=%b",
                 k, ldAck, cpuAck, (k == 4 || k == 11), (k == 7 || k == 14));
      end
      if (k == 7) begin
        nvec++;
        if (cpuQ !== 8'h5A) begin
          nerr++;
          $display("FAIL rr_cpuq got %h expected 5a", cpuQ);
        end
      end
      if (k == 14) begin ldRq = 1'b0; cpuRq = 1'b0; end
    end
    nvec++;
    if (vidQ !== 8'hA5) begin
      nerr++;
      $display("FAIL vidq_hold got %h expected a5", vidQ);
    end
  endtask

  task automatic test_ld_write();
    ldA = 22'h000010; ldD = 8'h3C; ldRq = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      nvec++;
      if (sramWe !== (k != 2) || sramDqOe !== (k <= 3) || ldAck !== (k == 4)) begin
        nerr++;
        $display("FAIL ldwr k=%0d got we=%b dqoe=%b ack=%b expected %b/%b/%b",
                 k, sramWe, sramDqOe, ldAck, (k != 2), (k <= 3), (k == 4));
      end
      if (k == 1) begin
        nvec++;
        if (sramDqO !== 16'h3C3C || sramLb !== 1'b0 || sramUb !== 1'b1 || sramA !== 21'h000008) begin
          nerr++;
          $display("FAIL ldwr_bus got DqO=%h lb=%b ub=%b A=%h expected 3c3c/0/1/000008",
                   sramDqO, sramLb, sramUb, sramA);
        end
      end
      if (k == 4) begin
        nvec++;
        if (sramLb !== 1'b1) begin
          nerr++;
          $display("FAIL ldwr_release got lb=%b expected 1", sramLb);
        end
        ldRq = 1'b0;
      end
    end
  endtask

  task automatic test_all_three();
    reset = 1'b1; tick(); reset = 1'b0;
    sramDqI = 16'h1234;
    vidA = 22'h000008; vidRq = 1'b1;
    ldA = 22'h000030; ldD = 8'h99; ldRq = 1'b1;
    cpuA = 22'h000041; cpuWe = 1'b0; cpuRq = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      nvec++;
      if ({vidAck, ldAck, cpuAck} !== {1'(k == 3), 1'(k == 7), 1'(k == 10)}) begin
        nerr++;
        $display("FAIL all3_order k=%0d got vid,ld,cpu=%b expected %b",
                 k, {vidAck, ldAck, cpuAck}, {1'(k == 3), 1'(k == 7), 1'(k == 10)});
      end
      if (k == 3) vidRq = 1'b0;
      if (k == 7) ldRq = 1'b0;
      if (k == 10) cpuRq = 1'b0;
    end
    nvec++;
    if (vidQ !== 8'h34 || cpuQ !== 8'h12) begin
      nerr++;
      $display("FAIL all3_data got vidQ=%h cpuQ=%h expected 34/12", vidQ, cpuQ);
    end
  endtask

  // CPU write granted, video raised the cycle after: write completes, then
  // video is served on the edge that closes the CPU ack cycle.
  task automatic test_vid_preempt();
    cpuA = 22'h000101; cpuD = 8'h77; cpuWe = 1'b1; cpuRq = 1'b1;
    sramDqI = 16'hBEEF;
    tick();
    vidA = 22'h000006; vidRq = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 3) begin
        nvec++;
        if (sramDqOe !== 1'b1 || sramDqO !== 16'h7777 || sramA !== 21'h000080 || sramUb !== 1'b0) begin
          nerr++;
          $display("FAIL preempt_wr k=%0d got dqoe=%b DqO=%h A=%h ub=%b expected 1/7777/000080/0",
                   k, sramDqOe, sramDqO, sramA, sramUb);
        end
      end
      if (k == 5) begin
        nvec++;
        if (sramA !== 21'h000003 || sramOe !== 1'b0 || sramLb !== 1'b0) begin
          nerr++;
          $display("FAIL preempt_rd got A=%h oe=%b lb=%b expected 000003/0/0", sramA, sramOe, sramLb);
        end
      end
      nvec++;
      if (cpuAck !== (k == 4) || vidAck !== (k == 7)) begin
        nerr++;
        $display("FAIL preempt_ack k=%0d got cpu=%b vid=%b expected %b/%b",
                 k, cpuAck, vidAck, (k == 4), (k == 7));
      end
      if (k == 4) cpuRq = 1'b0;
      if (k == 7) vidRq = 1'b0;
      if (k < 7) tick();
    end
    nvec++;
    if (vidQ !== 8'hEF) begin
      nerr++;
      $display("FAIL preempt_vidq got %h expected ef", vidQ);
    end
    tick();
  endtask

  task automatic test_reset_midwrite();
    ldA = 22'h000050; ldD = 8'h42; ldRq = 1'b1;
    tick(); tick();
    nvec++;
    if (sramWe !== 1'b0) begin
      nerr++;
      $display("FAIL midwr_in_wr1 got we=%b expected 0", sramWe);
    end
    reset = 1'b1; ldRq = 1'b0;
    tick();
    nvec++;
    if ({sramWe, sramOe, sramUb, sramLb, sramDqOe} !== 5'b11110 || sramA !== '0 || ldAck !== 1'b0) begin
      nerr++;
      $display("FAIL midwr_reset got we,oe,ub,lb,dqoe=%b A=%h ldAck=%b expected 11110/0/0",
               {sramWe, sramOe, sramUb, sramLb, sramDqOe}, sramA, ldAck);
    end
    nvec++;
    if (vidQ !== 8'h00 || cpuQ !== 8'h00) begin
      nerr++;
      $display("FAIL midwr_q got vidQ=%h cpuQ=%h expected 00/00", vidQ, cpuQ);
    end
    reset = 1'b0;
    vidA = 22'h000003; vidRq = 1'b1; sramDqI = 16'hA55A;
    for (int k = 1; k <= 6; k++) begin
      tick();
      nvec++;
      if (ldAck !== 1'b0 || cpuAck !== 1'b0 || vidAck !== (k == 3)) begin
        nerr++;
        $display("FAIL midwr_after k=%0d got ld=%b cpu=%b vid=%b expected 0/0/%b",
                 k, ldAck, cpuAck, vidAck, (k == 3));
      end
      if (k == 3) vidRq = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    vidRq = 1'b0; ldRq = 1'b0; cpuRq = 1'b0; cpuWe = 1'b0;
    vidA = '0; ldA = '0; cpuA = '0; ldD = 8'h00; cpuD = 8'h00;
    sramDqI = 16'h0000;
    test_reset();
    test_vid_read();
    test_mask();
    test_rr();
    test_ld_write();
    test_all_three();
    test_vid_preempt();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
